// File: rtl/sys_pkg.sv
// Shared definitions for the SPI-controlled system block: command codes,
// command FSM state encoding, response constants and the response-byte helper.
package sys_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CFG_W  = 32;
  localparam int unsigned LEN_W  = 24;
  localparam int unsigned JOY_W  = 12;

  localparam logic [7:0] CMD_ID    = 8'h01;
  localparam logic [7:0] CMD_CFG   = 8'h02;
  localparam logic [7:0] CMD_OVL   = 8'h03;
  localparam logic [7:0] CMD_COLOR = 8'h04;
  localparam logic [7:0] CMD_JOY1  = 8'h05;
  localparam logic [7:0] CMD_JOY2  = 8'h06;
  localparam logic [7:0] CMD_ROM   = 8'h07;

  localparam logic [7:0] RESP_M = 8'h4D;
  localparam logic [7:0] RESP_C = 8'h43;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_RESP,
    ST_ROM_LEN,
    ST_ROM_DATA,
    ST_DONE
  } state_t;

  // Response byte number idx (0 = first byte after the command) for cmd.
  function automatic logic [7:0] resp_byte(input logic [7:0]       cmd,
                                           input logic [2:0]       idx,
                                           input logic [7:0]       core_id,
                                           input logic [JOY_W-1:0] joy);
    logic [7:0] b;
    b = 8'h00;
    case (cmd)
      CMD_ID: begin
        case (idx)
          3'd0:    b = RESP_M;
          3'd1:    b = RESP_C;
          3'd2:    b = core_id;
          default: b = 8'h00;
        endcase
      end
      CMD_JOY1, CMD_JOY2: begin
        case (idx)
          3'd0:    b = {4'h0, joy[11:8]};
          3'd1:    b = joy[7:0];
          default: b = 8'h00;
        endcase
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_slave.sv
// SPI mode-0 byte shifter, MSB first, oversampled in the clk domain.
// Ports: clk/reset; cs_n/sck/mosi raw SPI pins; tx_byte next byte to send
// (loaded the cycle after done); active = selected and armed; rx_byte/done
// received byte with one-cycle strobe; miso = tx shifter MSB.
module spi_slave
  import sys_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              mosi,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic              active,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              done,
  output logic              miso
);

  logic [1:0]        cs_sync;
  logic [1:0]        sck_sync;
  logic [1:0]        mosi_sync;
  logic              sck_prev;
  logic              settled;
  logic              armed;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_sr;
  logic [BYTE_W-1:0] tx_sr;
  logic              rise_c;

  assign rise_c = sck_sync[1] & ~sck_prev;
  assign active = armed & ~cs_sync[1];
  assign miso   = tx_sr[7];

  // Synchronizers, edge detect and shift registers.
  // armed only sets once a genuine CS-high has passed the synchronizer after
  // reset, so a transaction interrupted by reset cannot resume mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
      settled   <= 1'b0;
      armed     <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'd0;
      tx_sr     <= 8'd0;
      rx_byte   <= 8'd0;
      done      <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs_n};
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_prev  <= sck_sync[1];
      settled   <= 1'b1;
      done      <= 1'b0;
      if (settled && (cs_sync == 2'b11)) armed <= 1'b1;
      if (!active) begin
        bit_cnt <= 3'd0;
        tx_sr   <= 8'd0;
      end else begin
        if (done)        tx_sr <= tx_byte;
        else if (rise_c) tx_sr <= {tx_sr[6:0], 1'b0};
        if (rise_c) begin
          rx_sr   <= {rx_sr[5:0], mosi_sync[1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_byte <= {rx_sr, mosi_sync[1]};
            done    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sys.sv
// SPI command block: decodes command bytes from spi_slave and maintains the
// configuration, overlay, joystick-readback and ROM-download registers.
// Ports: clk/reset; sspi_* SPI slave pins; overlay/overlay_color overlay
// control (overlay_x/y unused); joy1/joy2 joystick inputs; core_config
// configuration word; rom_loading/rom_do/rom_do_valid ROM byte stream.
module sys
  import sys_pkg::*;
#(
  parameter int unsigned FREQ    = 21_477_000,
  parameter logic [7:0]  CORE_ID = 8'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sspi_cs,
  input  logic              sspi_clk,
  input  logic              sspi_mosi,
  output logic              sspi_miso,
  output logic              overlay,
  input  logic [7:0]        overlay_x,
  input  logic [7:0]        overlay_y,
  output logic [14:0]       overlay_color,
  input  logic [JOY_W-1:0]  joy1,
  input  logic [JOY_W-1:0]  joy2,
  output logic [CFG_W-1:0]  core_config,
  output logic              rom_loading,
  output logic [BYTE_W-1:0] rom_do,
  output logic              rom_do_valid
);

  logic              active;
  logic [BYTE_W-1:0] rx_byte;
  logic              done;
  logic [BYTE_W-1:0] tx_byte_c;

  state_t            state, state_n;
  logic [7:0]        cmd, cmd_n;
  logic [1:0]        cnt, cnt_n;
  logic [LEN_W-1:0]  arg, arg_n;
  logic [LEN_W-1:0]  rom_cnt, rom_cnt_n;
  logic [2:0]        idx, idx_n;
  logic [JOY_W-1:0]  joy, joy_n;
  logic [CFG_W-1:0]  core_config_n;
  logic              overlay_n;
  logic [14:0]       overlay_color_n;
  logic              rom_loading_n;
  logic [BYTE_W-1:0] rom_do_n;
  logic              rom_do_valid_n;
  logic [LEN_W-1:0]  arg_shift_c;
  logic [JOY_W-1:0]  joy_dec_c;

  logic unused;
  assign unused = ^{overlay_x, overlay_y, 32'(FREQ)};

  spi_slave u_spi (
    .clk     (clk),
    .reset   (reset),
    .cs_n    (sspi_cs),
    .sck     (sspi_clk),
    .mosi    (sspi_mosi),
    .tx_byte (tx_byte_c),
    .active  (active),
    .rx_byte (rx_byte),
    .done    (done),
    .miso    (sspi_miso)
  );

  assign arg_shift_c = {arg[15:0], rx_byte};
  assign joy_dec_c   = (rx_byte == CMD_JOY2) ? joy2 : joy1;

  // State and register update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cmd           <= 8'd0;
      cnt           <= 2'd0;
      arg           <= '0;
      rom_cnt       <= '0;
      idx           <= 3'd0;
      joy           <= '0;
      core_config   <= '0;
      overlay       <= 1'b0;
      overlay_color <= 15'd0;
      rom_loading   <= 1'b0;
      rom_do        <= 8'd0;
      rom_do_valid  <= 1'b0;
    end else begin
      state         <= state_n;
      cmd           <= cmd_n;
      cnt           <= cnt_n;
      arg           <= arg_n;
      rom_cnt       <= rom_cnt_n;
      idx           <= idx_n;
      joy           <= joy_n;
      core_config   <= core_config_n;
      overlay       <= overlay_n;
      overlay_color <= overlay_color_n;
      rom_loading   <= rom_loading_n;
      rom_do        <= rom_do_n;
      rom_do_valid  <= rom_do_valid_n;
    end
  end

  // Command FSM. tx_byte_c is only consumed by spi_slave on the cycle done is
  // high, so it is computed from the pre-transition state.
  always_comb begin
    state_n         = state;
    cmd_n           = cmd;
    cnt_n           = cnt;
    arg_n           = arg;
    rom_cnt_n       = rom_cnt;
    idx_n           = idx;
    joy_n           = joy;
    core_config_n   = core_config;
    overlay_n       = overlay;
    overlay_color_n = overlay_color;
    rom_loading_n   = rom_loading;
    rom_do_n        = rom_do;
    rom_do_valid_n  = 1'b0;
    tx_byte_c       = 8'h00;

    if (!active) begin
      state_n       = ST_IDLE;
      cnt_n         = 2'd0;
      idx_n         = 3'd0;
      rom_cnt_n     = '0;
      rom_loading_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (done) begin
            cmd_n     = rx_byte;
            arg_n     = '0;
            idx_n     = 3'd1;
            joy_n     = joy_dec_c;
            tx_byte_c = resp_byte(rx_byte, 3'd0, CORE_ID, joy_dec_c);
            case (rx_byte)
              CMD_ID, CMD_JOY1, CMD_JOY2: state_n = ST_RESP;
              CMD_CFG:   begin state_n = ST_ARGS; cnt_n = 2'd3; end
              CMD_OVL:   begin state_n = ST_ARGS; cnt_n = 2'd0; end
              CMD_COLOR: begin state_n = ST_ARGS; cnt_n = 2'd1; end
              CMD_ROM: begin
                state_n       = ST_ROM_LEN;
                cnt_n         = 2'd2;
                rom_loading_n = 1'b1;
              end
              default:   begin state_n = ST_ARGS; cnt_n = 2'd0; end
            endcase
          end
        end
        ST_ARGS: begin
          if (done) begin
            arg_n = arg_shift_c;
            if (cnt == 2'd0) begin
              state_n = ST_DONE;
              case (cmd)
                CMD_CFG:   core_config_n   = {arg, rx_byte};
                CMD_OVL:   overlay_n       = rx_byte[0];
                CMD_COLOR: overlay_color_n = {arg[6:0], rx_byte};
                default:   ;
              endcase
            end else begin
              cnt_n = cnt - 2'd1;
            end
          end
        end
        ST_RESP: begin
          if (done) begin
            tx_byte_c = resp_byte(cmd, idx, CORE_ID, joy);
            if (idx != 3'd7) idx_n = idx + 3'd1;
          end
        end
        ST_ROM_LEN: begin
          if (done) begin
            arg_n = arg_shift_c;
            if (cnt == 2'd0) begin
              if (arg_shift_c == '0) begin
                state_n       = ST_DONE;
                rom_loading_n = 1'b0;
              end else begin
                state_n   = ST_ROM_DATA;
                rom_cnt_n = arg_shift_c;
              end
            end else begin
              cnt_n = cnt - 2'd1;
            end
          end
        end
        ST_ROM_DATA: begin
          // Stays one cycle past the last strobe so rom_loading drops after it.
          if (rom_cnt == '0) begin
            state_n       = ST_DONE;
            rom_loading_n = 1'b0;
          end else if (done) begin
            rom_do_n       = rx_byte;
            rom_do_valid_n = 1'b1;
            rom_cnt_n      = rom_cnt - 24'd1;
          end
        end
        ST_DONE: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys.sv
// Self-checking bench for sys: drives SPI transactions as a mode-0 master and
// compares read-back bytes and register effects against a transaction-level model.
module tb_sys;

  localparam int unsigned PH = 5;
  localparam logic [7:0]  CORE_ID_EXP = 8'h01;

  logic        clk = 1'b0;
  logic        reset;
  logic        sspi_cs, sspi_clk, sspi_mosi, sspi_miso;
  logic        overlay;
  logic [7:0]  overlay_x, overlay_y;
  logic [14:0] overlay_color;
  logic [11:0] joy1, joy2;
  logic [31:0] core_config;
  logic        rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;

  always #5 clk = ~clk;

  sys dut (
    .clk           (clk),
    .reset         (reset),
    .sspi_cs       (sspi_cs),
    .sspi_clk      (sspi_clk),
    .sspi_mosi     (sspi_mosi),
    .sspi_miso     (sspi_miso),
    .overlay       (overlay),
    .overlay_x     (overlay_x),
    .overlay_y     (overlay_y),
    .overlay_color (overlay_color),
    .joy1          (joy1),
    .joy2          (joy2),
    .core_config   (core_config),
    .rom_loading   (rom_loading),
    .rom_do        (rom_do),
    .rom_do_valid  (rom_do_valid)
  );

  int checks = 0;
  int passes = 0;

  // Model state
  logic [31:0] m_cfg;
  logic        m_ovl;
  logic [14:0] m_color;
  logic [7:0]  m_rom_do;

  logic [7:0] args_q[$];
  logic [7:0] rom_cap[$];
  int         wide = 0;
  logic       prev_v = 1'b0;

  // ROM strobe monitor
  always @(negedge clk) begin
    if (rom_do_valid) rom_cap.push_back(rom_do);
    if (rom_do_valid && prev_v) wide++;
    prev_v = rom_do_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_config"}, core_config, 32'h0);
    check({tag, "_overlay"}, 32'(overlay), 32'h0);
    check({tag, "_overlay_color"}, 32'(overlay_color), 32'h0);
    check({tag, "_rom_loading"}, 32'(rom_loading), 32'h0);
    check({tag, "_rom_do"}, 32'(rom_do), 32'h0);
    check({tag, "_rom_do_valid"}, 32'(rom_do_valid), 32'h0);
    check({tag, "_miso"}, 32'(sspi_miso), 32'h0);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sspi_mosi = tx[i];
      repeat (PH) @(negedge clk);
      rx[i] = sspi_miso;
      sspi_clk = 1'b1;
      repeat (PH) @(negedge clk);
      sspi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    sspi_cs = 1'b0;
    repeat (PH) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (PH) @(negedge clk);
    sspi_cs = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  // Expected byte read back at position k after the command byte.
  function automatic logic [7:0] model_resp(input logic [7:0] cmd, input int k);
    logic [7:0] id_bytes [4];
    logic [7:0] r;
    id_bytes = '{8'h4D, 8'h43, CORE_ID_EXP, 8'h00};
    r = 8'h00;
    if (cmd == 8'h01 && k < 4)      r = id_bytes[k];
    else if (cmd == 8'h05 && k == 0) r = {4'h0, joy1[11:8]};
    else if (cmd == 8'h05 && k == 1) r = joy1[7:0];
    else if (cmd == 8'h06 && k == 0) r = {4'h0, joy2[11:8]};
    else if (cmd == 8'h06 && k == 1) r = joy2[7:0];
    return r;
  endfunction

  task automatic model_reset();
    m_cfg = 32'h0; m_ovl = 1'b0; m_color = 15'h0; m_rom_do = 8'h0;
  endtask

  // One complete transaction: cmd followed by args_q, then CS high.
  task automatic run_txn(input logic [7:0] cmd);
    logic [7:0] rx;
    logic [7:0] exp_rom[$];
    int         base;
    int         n;
    int         len;
    logic       exp_load;
    base = rom_cap.size();
    n    = args_q.size();
    cs_low();
    spi_byte(cmd, rx);
    check($sformatf("c%02h_cmd_miso", cmd), 32'(rx), 32'h0);
    for (int k = 0; k < n; k++) begin
      spi_byte(args_q[k], rx);
      check($sformatf("c%02h_rsp%0d", cmd, k), 32'(rx), 32'(model_resp(cmd, k)));
    end
    repeat (3) @(negedge clk);
    exp_load = 1'b0;
    case (cmd)
      8'h02: if (n >= 4) m_cfg = {args_q[0], args_q[1], args_q[2], args_q[3]};
      8'h03: if (n >= 1) m_ovl = args_q[0][0];
      8'h04: if (n >= 2) m_color = 15'({args_q[0], args_q[1]} & 16'h7FFF);
      8'h07: begin
        if (n < 3) exp_load = 1'b1;
        else begin
          len = int'({args_q[0], args_q[1], args_q[2]});
          for (int k = 0; k < len && 3 + k < n; k++) exp_rom.push_back(args_q[3 + k]);
          exp_load = (exp_rom.size() < len);
          if (exp_rom.size() > 0) m_rom_do = exp_rom[exp_rom.size() - 1];
        end
      end
      default: ;
    endcase
    check($sformatf("c%02h_rom_loading_cs_low", cmd), 32'(rom_loading), 32'(exp_load));
    cs_high();
    check($sformatf("c%02h_rom_loading_cs_high", cmd), 32'(rom_loading), 32'h0);
    check($sformatf("c%02h_core_config", cmd), core_config, m_cfg);
    check($sformatf("c%02h_overlay", cmd), 32'(overlay), 32'(m_ovl));
    check($sformatf("c%02h_overlay_color", cmd), 32'(overlay_color), 32'(m_color));
    check($sformatf("c%02h_rom_do", cmd), 32'(rom_do), 32'(m_rom_do));
    check($sformatf("c%02h_rom_count", cmd), 32'(rom_cap.size() - base), 32'(exp_rom.size()));
    for (int k = 0; k < exp_rom.size(); k++)
      if (base + k < rom_cap.size())
        check($sformatf("c%02h_rom_byte%0d", cmd, k), 32'(rom_cap[base + k]), 32'(exp_rom[k]));
  endtask

  task automatic set_args32(input logic [31:0] v);
    args_q = {};
    for (int i = 3; i >= 0; i--) args_q.push_back(8'(v >> (8 * i)));
  endtask

  initial begin
    logic [7:0] rx;
    int         n;
    reset = 1'b1; sspi_cs = 1'b1; sspi_clk = 1'b0; sspi_mosi = 1'b0;
    joy1 = 12'h0; joy2 = 12'h0;
    overlay_x = 8'($urandom); overlay_y = 8'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("after_reset");

    // Identification readback
    args_q = {};
    repeat (6) args_q.push_back(8'($urandom));
    run_txn(8'h01);

    // Configuration word
    set_args32(32'hA5A5A5A5);
    run_txn(8'h02);
    repeat (3) begin
      set_args32($urandom);
      run_txn(8'h02);
    end

    // Partial configuration leaves core_config unchanged
    args_q = {8'h12, 8'h34};
    run_txn(8'h02);
    repeat (2) begin
      args_q = {};
      n = $urandom_range(0, 3);
      repeat (n) args_q.push_back(8'($urandom));
      run_txn(8'h02);
    end

    // Overlay colour, bit 15 dropped
    args_q = {8'hFF, 8'hFF};
    run_txn(8'h04);
    repeat (2) begin
      args_q = {8'($urandom), 8'($urandom)};
      run_txn(8'h04);
    end
    args_q = {8'h55};
    run_txn(8'h04);

    // ROM download
    args_q = {8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    run_txn(8'h07);
    repeat (3) begin
      n = $urandom_range(1, 5);
      args_q = {8'h00, 8'h00, 8'(n)};
      repeat (n) args_q.push_back(8'($urandom));
      run_txn(8'h07);
    end
    args_q = {8'h00, 8'h00, 8'h05, 8'($urandom), 8'($urandom)};
    run_txn(8'h07);
    args_q = {8'h00, 8'h00, 8'h00, 8'h5A, 8'h66};
    run_txn(8'h07);

    // rom_loading rises at decode of the ROM command
    cs_low();
    spi_byte(8'h07, rx);
    repeat (4) @(negedge clk);
    check("rom_loading_at_decode", 32'(rom_loading), 32'h1);
    cs_high();
    check("rom_loading_cs_abort", 32'(rom_loading), 32'h0);

    // Joystick readback and overlay enable
    joy1 = 12'hABC;
    args_q = {8'h00, 8'h00};
    run_txn(8'h05);
    joy1 = 12'($urandom);
    joy2 = 12'($urandom);
    args_q = {8'($urandom), 8'($urandom), 8'($urandom)};
    run_txn(8'h05);
    args_q = {8'($urandom), 8'($urandom), 8'($urandom)};
    run_txn(8'h06);
    args_q = {8'h01};
    run_txn(8'h03);
    repeat (3) begin
      args_q = {8'($urandom), 8'($urandom)};
      run_txn(8'h03);
    end

    // Unknown commands have no effect
    repeat (2) begin
      args_q = {8'($urandom), 8'($urandom), 8'($urandom)};
      run_txn(8'($urandom_range(8, 255)));
    end
    args_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_txn(8'h00);

    // Reset in the middle of a ROM stream
    args_q = {8'h01, 8'hFF};
    run_txn(8'h04);
    cs_low();
    spi_byte(8'h07, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h0A, rx);
    spi_byte(8'hDE, rx);
    spi_byte(8'hAD, rx);
    repeat (3) @(negedge clk);
    check("mid_rom_loading", 32'(rom_loading), 32'h1);
    check("mid_rom_do", 32'(rom_do), 32'hAD);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    // CS still low: bytes must be ignored until CS toggles
    spi_byte(8'h03, rx);
    spi_byte(8'h01, rx);
    repeat (10) @(negedge clk);
    check("no_rearm_overlay", 32'(overlay), 32'h0);
    check("no_rearm_rom_loading", 32'(rom_loading), 32'h0);
    cs_high();
    args_q = {8'h01};
    run_txn(8'h03);

    check("strobe_width", 32'(wide), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
